// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, state type and select decoder for stream_demux_1ton
package demux_pkg;
  localparam int CNT_W = 16;
  localparam int MAX_OUT = 64;
  typedef enum logic {EMPTY, FULL} state_e;
  // One-hot decode of a channel select; all zeros when the select names no channel
  function automatic logic [MAX_OUT-1:0] sel_to_onehot(input logic [5:0] sel, input int n);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (int'(sel) < n) v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N stream demux with single-entry holding register; DEMUX_CNT_EN adds per-channel transfer counters
module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   sel_err
`ifdef DEMUX_CNT_EN
  ,output logic [N_OUT*CNT_W-1:0] chan_cnt
`endif
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic sel_err_q, sel_err_d;
  logic in_ok, accept, drain;
  // Decode, handshake and next-state; the held word drains and a new one loads in the same cycle
  always_comb begin
    in_ok = |N_OUT'(sel_to_onehot(6'(in_sel), N_OUT));
    out_valid = state_q == FULL ? N_OUT'(sel_to_onehot(6'(sel_q), N_OUT)) : '0;
    drain = |(out_valid & out_ready);
    in_ready = !rst && en && (state_q == EMPTY || drain);
    accept = in_valid && in_ready;
    state_d = accept && in_ok ? FULL : drain ? EMPTY : state_q;
    data_d = accept && in_ok ? in_data : data_q;
    sel_d = accept && in_ok ? in_sel : sel_q;
    sel_err_d = accept && !in_ok;
    for (int i = 0; i < N_OUT; i++) out_data[i*WIDTH +: WIDTH] = out_valid[i] ? data_q : '0;
  end
  // Holding register; reset discards any held word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      sel_err_q <= sel_err_d;
    end
  assign sel_err = sel_err_q;
`ifdef DEMUX_CNT_EN
  logic [N_OUT*CNT_W-1:0] cnt_q, cnt_d;
  // Count completed output transfers per channel, wrapping, independent of en
  always_comb begin
    for (int i = 0; i < N_OUT; i++)
      cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(out_valid[i] & out_ready[i]);
  end
  // Counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign chan_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton: directed and randomized checks of stream_demux_1ton (N_OUT=6) against a transaction-level model
module tb_stream_demux_1ton;
  localparam int W = 8;
  localparam int N = 6;
  localparam int S = $clog2(N);
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, in_valid = 1'b0, in_ready, sel_err;
  logic [W-1:0] in_data = '0;
  logic [S-1:0] in_sel = '0;
  logic [N-1:0] out_valid, out_ready = '0;
  logic [N*W-1:0] out_data;
`ifdef DEMUX_CNT_EN
  logic [N*16-1:0] chan_cnt;
`endif
  int tests = 0, fails = 0;
  bit m_full, m_err;
  logic [W-1:0] m_data;
  int m_sel;

  always #5 clk = ~clk;

  stream_demux_1ton #(.WIDTH(W), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err)
`ifdef DEMUX_CNT_EN
    , .chan_cnt(chan_cnt)
`endif
  );

  function automatic logic exp_ready();
    return !rst && en && (!m_full || out_ready[m_sel]);
  endfunction
  function automatic logic [N-1:0] exp_valid();
    return m_full ? N'(1) << m_sel : '0;
  endfunction
  function automatic logic [N*W-1:0] exp_data();
    logic [N*W-1:0] v;
    v = '0;
    if (m_full) v[m_sel*W +: W] = m_data;
    return v;
  endfunction

  // Advance the model by one transfer cycle, then move to just after the clock edge
  task automatic tick();
    bit acc;
    acc = in_valid && exp_ready();
    if (rst) begin
      m_full = 0; m_err = 0;
    end else begin
      m_err = acc && int'(in_sel) >= N;
      if (acc && int'(in_sel) < N) begin
        m_full = 1; m_data = in_data; m_sel = int'(in_sel);
      end else if (m_full && out_ready[m_sel]) m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    en = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tick(); tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_sel = 3'd3; out_ready = '0;
    tick();
    in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 6'b001000) begin fails++; $display("FAIL hold_a5_valid got %b exp 001000", out_valid); end
    tests++; if (out_data[3*W +: W] !== 8'hA5) begin fails++; $display("FAIL hold_a5_data got %h exp a5", out_data[3*W +: W]); end
    rst = 1'b1; m_full = 0; m_err = 0;
    #1;
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL async_rst_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL async_rst_data got %h exp 0", out_data); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL async_rst_ready got %b exp 0", in_ready); end
    tick();
    rst = 1'b0; out_ready = '1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b exp 1", in_ready); end
    tick();
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL post_rst_stale got %b exp 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = '1; en = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i); in_sel = S'(i);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      tests++; if (out_valid !== N'(1) << i) begin fails++; $display("FAIL stream_valid[%0d] got %b exp %b", i, out_valid, N'(1) << i); end
      tests++; if (out_data !== (N*W)'(8'h10 + i) << (i*W)) begin fails++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, (N*W)'(8'h10 + i) << (i*W)); end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL stream_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = '0; in_valid = 1'b1; in_data = 8'h3C; in_sel = 3'd5;
    tick();
    in_data = 8'h55; in_sel = 3'd1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 0", c, in_ready); end
      tests++; if (out_valid !== 6'b100000 || out_data[5*W +: W] !== 8'h3C) begin fails++; $display("FAIL bp_hold[%0d] got %b/%h exp 100000/3c", c, out_valid, out_data[5*W +: W]); end
      tick();
    end
    out_ready[5] = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 6'b000010 || out_data !== (N*W)'(8'h55) << W) begin fails++; $display("FAIL bp_next got %b/%h exp 000010/55 on ch1", out_valid, out_data); end
    out_ready = '1;
    tick();
  endtask

  task automatic test_out_of_range();
    out_ready = '1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 3'd7;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL oor_ready got %b exp 1", in_ready); end
    tick();
    tests++; if (out_valid !== '0 || sel_err !== 1'b1) begin fails++; $display("FAIL oor_drop got valid %b err %b exp 0/1", out_valid, sel_err); end
    in_data = 8'h77; in_sel = 3'd2;
    tick();
    tests++; if (sel_err !== 1'b0 || out_valid !== 6'b000100 || out_data[2*W +: W] !== 8'h77) begin fails++; $display("FAIL oor_follow got err %b valid %b data %h exp 0/000100/77", sel_err, out_valid, out_data[2*W +: W]); end
    in_data = 8'hEE; in_sel = 3'd6;
    tick();
    tests++; if (out_valid !== '0 || sel_err !== 1'b1) begin fails++; $display("FAIL oor_drain got valid %b err %b exp 0/1", out_valid, sel_err); end
    in_valid = 1'b0;
    tick();
    tests++; if (sel_err !== 1'b0) begin fails++; $display("FAIL oor_pulse got %b exp 0", sel_err); end
  endtask

  task automatic test_enable();
    out_ready = '0; en = 1'b1; in_valid = 1'b1; in_data = 8'h42; in_sel = 3'd1;
    tick();
    en = 1'b0; in_data = 8'h99; in_sel = 3'd4;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL en_ready_full got %b exp 0", in_ready); end
    tick();
    tests++; if (out_valid !== 6'b000010 || out_data[W +: W] !== 8'h42) begin fails++; $display("FAIL en_hold got %b/%h exp 000010/42", out_valid, out_data[W +: W]); end
    out_ready = '1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL en_ready_drain got %b exp 0", in_ready); end
    tick();
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL en_drained got %b exp 0", out_valid); end
    tick();
    tests++; if (out_valid !== '0) begin fails++; $display("FAIL en_no_accept got %b exp 0", out_valid); end
    en = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL en_resume_ready got %b exp 1", in_ready); end
    tick();
    tests++; if (out_valid !== 6'b010000 || out_data[4*W +: W] !== 8'h99) begin fails++; $display("FAIL en_resume got %b/%h exp 010000/99", out_valid, out_data[4*W +: W]); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en = $urandom_range(0, 7) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = W'($urandom);
      in_sel = S'($urandom_range(0, 7));
      out_ready = N'($urandom);
      #1;
      tests++; if (in_ready !== exp_ready()) begin fails++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, in_ready, exp_ready()); end
      tests++; if (out_valid !== exp_valid()) begin fails++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, exp_valid()); end
      tests++; if (out_data !== exp_data()) begin fails++; $display("FAIL rnd_data[%0d] got %h exp %h", c, out_data, exp_data()); end
      tests++; if (sel_err !== m_err) begin fails++; $display("FAIL rnd_sel_err[%0d] got %b exp %b", c, sel_err, m_err); end
      tick();
    end
    in_valid = 1'b0; out_ready = '1; en = 1'b1;
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; out_ready = '1; in_valid = 1'b1; in_sel = 3'd2;
    for (int i = 0; i < 3; i++) begin in_data = 8'(i); tick(); end
    in_sel = 3'd0;
    for (int i = 0; i < 65536; i++) begin in_data = 8'(i); tick(); end
    in_valid = 1'b0;
    tick();
    tests++; if (chan_cnt[2*16 +: 16] !== 16'd3) begin fails++; $display("FAIL cnt_ch2 got %0d exp 3", chan_cnt[2*16 +: 16]); end
    tests++; if (chan_cnt[0 +: 16] !== 16'd0) begin fails++; $display("FAIL cnt_ch0_wrap got %0d exp 0", chan_cnt[0 +: 16]); end
    tests++; if (chan_cnt[1*16 +: 16] !== 16'd0) begin fails++; $display("FAIL cnt_ch1 got %0d exp 0", chan_cnt[1*16 +: 16]); end
  endtask
`endif

  initial begin
    m_full = 0; m_err = 0; m_data = '0; m_sel = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_out_of_range();
    test_enable();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer.
- Successor to the gate-level 1-to-8 demux. It adds configurable data width and channel count, a single-entry output holding register, per-channel valid/ready handshakes and out-of-range select detection.
- Sits between a single producer and N consumer channels in datapath routing.

Parameters:
- WIDTH, 8, data bits per word.
- N_OUT, 8, number of output channels, 2..64.
- SEL_W, $clog2(N_OUT), select width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable. When 0, no new words are accepted; a held word still drains.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  producer word.
- in_sel  input  SEL_W  destination channel, sampled with in_data.
- out_valid  output  N_OUT  per-channel valid, at most one bit set.
- out_ready  input  N_OUT  per-channel ready.
- out_data  output  N_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- sel_err  output  1  one-cycle pulse: a word with in_sel >= N_OUT was accepted and dropped.

Behaviour:
- State: holding register (valid_q, data_q, sel_q); two states, EMPTY (valid_q=0) and FULL (valid_q=1).
- Reset: valid_q=0, data_q=0, sel_q=0, sel_err=0. All out_valid=0, out_data=0, in_ready=0 while rst is high.
- Reset asserted mid-operation discards the held word with no drain.
- in_ready = en && (!valid_q || out_ready[sel_q]). This is combinational and allows back-to-back transfers at 1 word/cycle.
- out_valid[i] = valid_q && (sel_q == i).
- out_data channel i = data_q when sel_q == i, else all zeros. Non-selected channels read 0, matching AND-gate demux semantics.
- Accept = in_valid && in_ready. Latency is 1 cycle: a word accepted at edge k appears on its channel after edge k.
- Transitions:
  - EMPTY, accept, in_sel valid → FULL.
  - FULL, out_ready[sel_q] && !accept → EMPTY.
  - FULL, out_ready[sel_q] && accept → FULL with the new word; the old word transfers in the same cycle.
  - FULL, !out_ready[sel_q] → FULL; data_q and sel_q are stable (no change while stalled).
- Out-of-range select: accept with in_sel >= N_OUT (only possible when N_OUT is not a power of 2):
  - The word is dropped; valid_q is cleared if the held word also drained, else unchanged.
  - sel_err = 1 for exactly the following cycle.
- en=0 while FULL: the held word drains normally and in_ready stays 0.
- Simultaneous in_valid and en falling in the same cycle: no accept.
- Back-pressure on channel j does not block other channels' earlier words, since at most one word is in flight. The producer stalls until j is ready.
- out_ready of non-selected channels is ignored.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined: adds output port chan_cnt, N_OUT*16 bits. It holds per-channel 16-bit counters of completed output transfers (out_valid[i] && out_ready[i]).
  - Counters wrap from 0xFFFF to 0x0000 and reset to 0.
  - They are not gated by en.
- Undefined: port and counters are absent; no other behaviour changes.

Decomposition:
- Package demux_pkg holds:
  - localparam CNT_W = 16.
  - function sel_to_onehot(sel, n) returning an N_OUT-bit one-hot vector, all zeros if sel >= n.
  - The state enum {EMPTY, FULL}.
- No sub-module: the decoder is the package function, and the block is a single module.

Test Plan:
- Reset: drive rst=1 mid-transfer while holding data 0xA5 for channel 3 -> out_valid=0, out_data=0, in_ready=0 during reset. After release with en=1, in_ready=1 and no stale word appears.
- Streaming: N_OUT=8, all out_ready=1, words 0x10..0x17 with sel 0..7 on consecutive cycles -> each appears one cycle later on its channel only, other channels read 0, throughput 1/cycle.
- Back-pressure: send 0x3C to channel 5 with out_ready[5]=0 for 4 cycles -> in_ready=0 and out_data ch5 holds 0x3C stable. Raise out_ready[5] -> transfer completes and in_ready rises the same cycle.
- Out-of-range: N_OUT=6, in_sel=7, in_data=0xFF accepted -> no out_valid, sel_err=1 for one cycle. A following valid word routes normally.
- Enable: en=0 while holding 0x42 for channel 1 with in_valid=1 -> the held word drains when out_ready[1]=1, and no new word is accepted until en=1.
- DEMUX_CNT_EN: 3 transfers to channel 2, then 65536 to channel 0 -> chan_cnt[2]=3 and chan_cnt[0]=0 (wrapped).
